result_width_narrow: RTL



---
 rtl/result_width_narrow_if.sv | 13 +
 rtl/result_width_narrow.sv | 89 ++++++++
 2 files changed

// File: rtl/result_width_narrow_if.sv
// AXI-Stream style handshake bundle shared by the 128-bit array side and the 32-bit DMA side.
// One instance per stream, with the data width set by W.
interface result_width_narrow_if #(
  parameter int W = 32
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (output tvalid, output tdata, output tlast, input  tready);
  modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/result_width_narrow.sv
// Serializes 128-bit array result words into 32-bit DMA beats, most-significant lane first,
// and closes a frame with tlast every FRAME_BEATS beats regardless of word alignment.
module result_width_narrow #(
  parameter int IN_W        = 128,
  parameter int OUT_W       = 32,
  parameter int LANES       = 4,
  parameter int FRAME_BEATS = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  result_width_narrow_if.slave    s_axis_res,
  result_width_narrow_if.master   m_axis_res
);
  localparam int              IDX_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [15:0]      LAST_BEAT = 16'(FRAME_BEATS - 1);

  typedef enum logic {EMPTY = 1'b0, SHIFT = 1'b1} state_t;

  state_t                       r_state;
  logic [IN_W-1:0]              r_hold;
  logic [IDX_W-1:0]             r_idx;
  logic [15:0]                  r_beat_cnt;

  logic [LANES-1:0][OUT_W-1:0]  w_lanes;
  logic                         w_full;
  logic                         w_last_lane;
  logic                         w_m_hs;
  logic                         w_s_rdy;
  logic                         w_s_hs;
  logic                         w_unused;

  // Lane 0 is the top slice of the word, matching the widening FIFO order.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lanes[g] = r_hold[IN_W-1-OUT_W*g -: OUT_W];
  end

  assign w_full      = (r_state == SHIFT);
  assign w_last_lane = (r_idx == LAST_IDX);
  assign w_m_hs      = w_full & m_axis_res.tready;
  // Ready looks through to downstream ready on the last lane so words chain without a bubble.
  assign w_s_rdy     = rst_n & (~w_full | (w_last_lane & m_axis_res.tready));
  assign w_s_hs      = s_axis_res.tvalid & w_s_rdy;

  assign s_axis_res.tready = w_s_rdy;
  assign m_axis_res.tvalid = w_full;
  assign m_axis_res.tdata  = w_lanes[r_idx];
  assign m_axis_res.tlast  = w_full & (r_beat_cnt == LAST_BEAT);

  // A word-level tlast from the array carries no meaning; frames are counted on output beats.
  assign w_unused = s_axis_res.tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_hold     <= '0;
      r_idx      <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_s_hs) begin
            r_hold  <= s_axis_res.tdata;
            r_idx   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_m_hs) begin
            if (!w_last_lane) begin
              r_idx <= r_idx + 1'b1;
            end else if (w_s_hs) begin
              r_hold <= s_axis_res.tdata;
              r_idx  <= '0;
            end else begin
              r_idx   <= '0;
              r_state <= EMPTY;
            end
          end
        end
        default: r_state <= EMPTY;
      endcase

      if (w_m_hs) begin
        r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? 16'd0 : r_beat_cnt + 16'd1;
      end
    end
  end
endmodule
